// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and counter width for the memory arbiter.
package mem_arb_pkg;
    localparam int LAT_W = 3;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable latency down-counter flagging its final count.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LAT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             is_one_o
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign is_one_o = (cnt_q == LAT_W'(1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch (I) and data (D) requesters.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             I_REQ,
    input  logic [WIDTH-1:0] I_ADDR,
    output logic [WIDTH-1:0] I_RDATA,
    output logic             I_VALID,
    input  logic             D_REQ,
    input  logic             D_WE,
    input  logic [WIDTH-1:0] D_ADDR,
    input  logic [WIDTH-1:0] D_WDATA,
    output logic [WIDTH-1:0] D_RDATA,
    output logic             D_VALID,
    output logic [WIDTH-1:0] M_ADDR,
    output logic             M_WE,
    output logic [WIDTH-1:0] M_WDATA,
    input  logic [WIDTH-1:0] M_RDATA,
    output logic             STALL
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic             m_we_q, m_we_d, store_q, store_d;
    logic             i_valid_q, i_valid_d, d_valid_q, d_valid_d;
    logic             grant_d, load_lat, is_one;

    assign load_lat = (state_q == IDLE) && (I_REQ || D_REQ);

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
    // On a tie, serve whoever was not served last.
    assign grant_d = D_REQ && (!I_REQ || last_q == OWN_I);
    always_comb last_d = load_lat ? (grant_d ? OWN_D : OWN_I) : last_q;
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) last_q <= OWN_I;
        else last_q <= last_d;
`else
    assign grant_d = D_REQ;
`endif

    arb_lat_counter u_lat (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .load_i  (load_lat),
        .val_i   (LAT_W'(MEM_LAT)),
        .dec_i   (state_q != IDLE),
        .is_one_o(is_one)
    );

    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = 1'b0;
        store_d   = store_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d   = BUSY_D;
                    m_addr_d  = D_ADDR;
                    m_wdata_d = D_WDATA;
                    m_we_d    = D_WE;
                    store_d   = D_WE;
                end else if (I_REQ) begin
                    state_d   = BUSY_I;
                    m_addr_d  = I_ADDR;
                    m_wdata_d = '0;
                    store_d   = 1'b0;
                end
            end
            BUSY_I: if (is_one) begin
                state_d   = IDLE;
                i_rdata_d = M_RDATA;
                i_valid_d = 1'b1;
            end
            BUSY_D: if (is_one) begin
                state_d   = IDLE;
                d_rdata_d = store_q ? d_rdata_q : M_RDATA;
                d_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            state_q   <= IDLE;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
            store_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
            store_q   <= store_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
        end

    assign M_ADDR  = m_addr_q;
    assign M_WDATA = m_wdata_q;
    assign M_WE    = m_we_q;
    assign I_RDATA = i_rdata_q;
    assign D_RDATA = d_rdata_q;
    assign I_VALID = i_valid_q;
    assign D_VALID = d_valid_q;
    assign STALL   = (I_REQ && !I_VALID) || (D_REQ && !D_VALID);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (MEM_LAT 2, plus 1 and 7 sweeps).
module tb_mem_arbiter;
    localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  inst;
        logic        d;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0, cyc = 0;

    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic        I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0;
    logic [31:0] I_ADDR = '0, D_ADDR = '0, D_WDATA = '0, M_RDATA = '0;
    logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_WDATA;
    logic        I_VALID, D_VALID, M_WE, STALL;

    logic        s_req = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] s1_ird, s1_drd, s1_ma, s1_mwd, s7_ird, s7_drd, s7_ma, s7_mwd;
    logic        s1_iv, s1_dv, s1_mwe, s1_st, s7_iv, s7_dv, s7_mwe, s7_st;

    logic [31:0]   ram [0:1023];
    logic [1023:0] wr_v = '0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : a ^ 32'h5A5A0000;
    endfunction

    always @(posedge CLK) if (M_WE) begin
        ram[M_ADDR[9:0]]  <= M_WDATA;
        wr_v[M_ADDR[9:0]] <= 1'b1;
    end
    always @(negedge CLK) M_RDATA <= wr_v[M_ADDR[9:0]] ? ram[M_ADDR[9:0]] : dflt(M_ADDR);

    mem_arbiter #(.WIDTH(32), .MEM_LAT(LAT)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_VALID(I_VALID),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_VALID(D_VALID),
        .M_ADDR(M_ADDR), .M_WE(M_WE), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
        .STALL(STALL)
    );

    mem_arbiter #(.WIDTH(32), .MEM_LAT(1)) u_lat1 (
        .CLK(CLK), .RESET_N(RESET_N),
        .I_REQ(s_req), .I_ADDR(s_addr), .I_RDATA(s1_ird), .I_VALID(s1_iv),
        .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR('0), .D_WDATA('0),
        .D_RDATA(s1_drd), .D_VALID(s1_dv),
        .M_ADDR(s1_ma), .M_WE(s1_mwe), .M_WDATA(s1_mwd), .M_RDATA(s1_ma ^ 32'hA5A50000),
        .STALL(s1_st)
    );

    mem_arbiter #(.WIDTH(32), .MEM_LAT(7)) u_lat7 (
        .CLK(CLK), .RESET_N(RESET_N),
        .I_REQ(s_req), .I_ADDR(s_addr), .I_RDATA(s7_ird), .I_VALID(s7_iv),
        .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR('0), .D_WDATA('0),
        .D_RDATA(s7_drd), .D_VALID(s7_dv),
        .M_ADDR(s7_ma), .M_WE(s7_mwe), .M_WDATA(s7_mwd), .M_RDATA(s7_ma ^ 32'hA5A50000),
        .STALL(s7_st)
    );

    task automatic push(input int k, input logic d, input logic [31:0] v, input int c);
        exp_t e;
        e.inst = 2'(k);
        e.d    = d;
        e.data = v;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic observe(input int k, input logic d, input logic [31:0] v);
        int   idx[$];
        exp_t e;
        idx = sbq.find_first_index(x) with (x.inst == 2'(k));
        checks++;
        if (idx.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid inst=%0d d=%0b data=%h cyc=%0d", k, d, v, cyc);
        end else begin
            e = sbq[idx[0]];
            sbq.delete(idx[0]);
            if (e.d !== d || e.data !== v || e.cyc != cyc) begin
                errors++;
                $display("FAIL resp inst=%0d got d=%0b data=%h cyc=%0d exp d=%0b data=%h cyc=%0d",
                         k, d, v, cyc, e.d, e.data, e.cyc);
            end
        end
    endtask

    initial forever begin
        @(negedge CLK);
        if (I_VALID) observe(0, 1'b0, I_RDATA);
        if (D_VALID) observe(0, 1'b1, D_RDATA);
        if (s1_iv)   observe(1, 1'b0, s1_ird);
        if (s1_dv)   observe(1, 1'b1, s1_drd);
        if (s7_iv)   observe(2, 1'b0, s7_ird);
        if (s7_dv)   observe(2, 1'b1, s7_drd);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_v(input logic d, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(d ? D_VALID : I_VALID) && n < 40);
        checks++;
        if (!(d ? D_VALID : I_VALID)) begin
            errors++;
            $display("FAIL %s timeout got=no_valid exp=valid cyc=%0d", nm, cyc);
        end
    endtask

    initial begin
        int g, nd, ni, n, c;
        logic dk;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_i_valid", 32'(I_VALID), 0);
        chk("rst_d_valid", 32'(D_VALID), 0);
        chk("rst_m_we", 32'(M_WE), 0);
        chk("rst_m_addr", M_ADDR, 0);
        chk("rst_m_wdata", M_WDATA, 0);
        chk("rst_i_rdata", I_RDATA, 0);
        chk("rst_d_rdata", D_RDATA, 0);
        chk("rst_stall", 32'(STALL), 0);
        RESET_N = 1'b1;
        tick();

        I_ADDR = 32'h40;
        I_REQ  = 1'b1;
        push(0, 1'b0, 32'hDEADBEEF, cyc + 1 + LAT);
        #1 chk("fetch_stall_wait", 32'(STALL), 1);
        wait_v(1'b0, "fetch");
        chk("fetch_stall_at_valid", 32'(STALL), 0);
        I_REQ = 1'b0;
        tick();

        D_ADDR  = 32'h100;
        D_WDATA = 32'h12345678;
        D_WE    = 1'b1;
        D_REQ   = 1'b1;
        push(0, 1'b1, 32'h0, cyc + 1 + LAT);
        tick();
        chk("store_m_we", 32'(M_WE), 1);
        chk("store_m_addr", M_ADDR, 32'h100);
        chk("store_m_wdata", M_WDATA, 32'h12345678);
        tick();
        chk("store_m_we_low", 32'(M_WE), 0);
        wait_v(1'b1, "store");
        D_REQ = 1'b0;
        D_WE  = 1'b0;
        tick();

        D_REQ = 1'b1;
        push(0, 1'b1, 32'h12345678, cyc + 1 + LAT);
        wait_v(1'b1, "readback");
        D_REQ = 1'b0;
        tick();

        g = cyc + 1;
        D_REQ = 1'b1;
        push(0, 1'b1, 32'h12345678, g + LAT);
        push(0, 1'b0, 32'hDEADBEEF, g + 2 * LAT + 1);
        tick();
        I_ADDR = 32'h40;
        I_REQ  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (D_VALID) D_REQ = 1'b0;
            #1 chk("pending_stall", 32'(STALL), 1);
            tick();
        end
        D_REQ = 1'b0;
        wait_v(1'b0, "pending_fetch");
        I_REQ = 1'b0;
        tick();

        g = cyc + 1;
        I_ADDR = 32'h40;
        D_ADDR = 32'h100;
        I_REQ  = 1'b1;
        D_REQ  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dk = RR ? (k % 2 == 0) : (k < 3);
            push(0, dk, dk ? 32'h12345678 : 32'hDEADBEEF, g + LAT + k * (LAT + 1));
        end
        nd = 0;
        ni = 0;
        n  = 0;
        while ((I_REQ || D_REQ) && n < 80) begin
            tick();
            n++;
            if (D_VALID && ++nd == 3) D_REQ = 1'b0;
            if (I_VALID && ++ni == 3) I_REQ = 1'b0;
        end
        chk("tie_done", 32'(I_REQ || D_REQ), 0);
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        tick();

        D_ADDR  = 32'h200;
        D_WDATA = 32'hCAFEF00D;
        D_WE    = 1'b1;
        D_REQ   = 1'b1;
        tick();
        chk("abort_m_we_pre", 32'(M_WE), 1);
        RESET_N = 1'b0;
        D_REQ   = 1'b0;
        D_WE    = 1'b0;
        #1;
        chk("abort_m_we", 32'(M_WE), 0);
        chk("abort_m_addr", M_ADDR, 0);
        chk("abort_d_rdata", D_RDATA, 0);
        chk("abort_i_rdata", I_RDATA, 0);
        tick();
        RESET_N = 1'b1;
        repeat (5) tick();
        D_REQ = 1'b1;
        push(0, 1'b1, 32'h5A5A0200, cyc + 1 + LAT);
        wait_v(1'b1, "abort_readback");
        D_REQ = 1'b0;
        tick();

        c = cyc;
        s_addr = 32'h80;
        s_req  = 1'b1;
        for (int e = c + 1; e <= c + 10; e += 2) push(1, 1'b0, 32'hA5A50080, e + 1);
        for (int e = c + 1; e <= c + 10; e += 8) push(2, 1'b0, 32'hA5A50080, e + 7);
        repeat (10) tick();
        s_req = 1'b0;
        repeat (20) tick();

        chk("sb_drain", 32'(sbq.size()), 0);
        chk("idle_stall", 32'(STALL), 0);
        chk("lat1_m_we", 32'(s1_mwe), 0);
        chk("lat1_m_wdata", s1_mwd, 0);
        chk("lat1_d_rdata", s1_drd, 0);
        chk("lat1_stall", 32'(s1_st), 0);
        chk("lat7_m_we", 32'(s7_mwe), 0);
        chk("lat7_m_wdata", s7_mwd, 0);
        chk("lat7_d_rdata", s7_drd, 0);
        chk("lat7_stall", 32'(s7_st), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
